mem_port_arbiter: RTL and testbench

- Shares the single external memory master port between the I-cache refill engine and the D-cache refill/writeback engine.
- Grants one requester at a time and locks the grant for a whole multi-beat burst.
- Sequences the beats, incrementing the address by 4 per beat, and returns per-beat acks, read data and a done pulse.
- Keeps redundant memory accesses off the bus on a cache miss: only the granted cache drives the port.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory master port between the I-cache refill engine
//   and the D-cache refill/writeback engine. One requester owns the port for a
//   whole burst; beats are sequenced with the address stepping by 4 per beat.
//
// Ports
//   clk, reset_n                      clock (rising edge), async active-low reset
//   i_req/i_addr/i_len                I-cache read burst request (len = beats-1)
//   d_req/d_we/d_addr/d_len/d_wdata   D-cache burst request and per-beat write data
//   i_gnt/d_gnt                       registered ownership of the port
//   i_ack/d_ack, i_done/d_done        per-beat accept and last-beat pulses
//   rdata                             read data returned with the ack
//   mem_req/mem_we/mem_addr/mem_wdata beat request to memory
//   mem_ready/mem_rdata               memory beat completion and read data
//
// state | meaning
// IDLE  | no burst in progress, arbitrate on i_req/d_req
// BUSY  | burst owned by the granted cache, one beat per mem_ready
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LEN_W-1:0]  d_len,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_gnt,
    output logic              d_gnt,
    output logic              i_ack,
    output logic              d_ack,
    output logic              i_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  len_q;
    logic              we_q;
    logic [SC_W-1:0]   starve_cnt;

    logic              starved;
    logic              i_win;
    logic              d_win;
    logic              beat;
    logic              last_beat;

    // D normally wins a tie; I wins once it has watched STARVE_LIMIT D grants.
    always_comb begin
        starved = (starve_cnt == SC_W'(STARVE_LIMIT));
        i_win   = i_req & (~d_req | starved);
        d_win   = d_req & ~i_win;
    end

    // mem_req follows the state register directly so reset drops it at once.
    assign mem_req   = (state == BUSY);
    assign mem_we    = mem_req & we_q;
    assign mem_wdata = d_wdata;
    assign rdata     = mem_rdata;

    assign beat      = mem_req & mem_ready;
    assign last_beat = (beat_cnt == len_q);
    assign i_ack     = beat & i_gnt;
    assign d_ack     = beat & d_gnt;
    assign i_done    = i_ack & last_beat;
    assign d_done    = d_ack & last_beat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            i_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            mem_addr   <= '0;
            beat_cnt   <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_win | d_win) begin
                        state    <= BUSY;
                        i_gnt    <= i_win;
                        d_gnt    <= d_win;
                        mem_addr <= i_win ? i_addr : d_addr;
                        len_q    <= i_win ? i_len : d_len;
                        we_q     <= d_win & d_we;
                        beat_cnt <= '0;
                        if (d_win && i_req) begin
                            if (!starved)
                                starve_cnt <= starve_cnt + SC_W'(1);
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_addr <= mem_addr + ADDR_W'(4);
                        if (last_beat) begin
                            state <= IDLE;
                            i_gnt <= 1'b0;
                            d_gnt <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: cycle-by-cycle vector table for the
//   single-burst, tie-break and wait-state cases, plus hand sequences for
//   starvation, mid-burst reset and address wrap with request drop.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [3:0]  i_len;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_len;
    logic [31:0] d_wdata;
    logic        i_gnt, d_gnt, i_ack, d_ack, i_done, d_done;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(4), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
        .i_gnt(i_gnt), .d_gnt(d_gnt), .i_ack(i_ack), .d_ack(d_ack),
        .i_done(i_done), .d_done(d_done), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // flags = {i_gnt, d_gnt, i_ack, d_ack, i_done, d_done}
    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic [3:0]  i_len;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [3:0]  d_len;
        logic [31:0] d_wdata;
        logic        rdy;
        logic [31:0] rd_in;
        logic [5:0]  e_flags;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic ir, input logic [31:0] ia, input logic [3:0] il,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [3:0] dl, input logic [31:0] wd,
                     input logic rdy, input logic [31:0] rd,
                     input logic [5:0] fl, input logic er, input logic ew,
                     input logic [31:0] ea);
        vec_t x;
        x.i_req = ir; x.i_addr = ia; x.i_len = il;
        x.d_req = dr; x.d_we = dw; x.d_addr = da; x.d_len = dl; x.d_wdata = wd;
        x.rdy = rdy; x.rd_in = rd;
        x.e_flags = fl; x.e_req = er; x.e_we = ew; x.e_addr = ea;
        vq.push_back(x);
    endtask

    task automatic apply(input vec_t x, input int idx);
        @(negedge clk);
        i_req = x.i_req; i_addr = x.i_addr; i_len = x.i_len;
        d_req = x.d_req; d_we = x.d_we; d_addr = x.d_addr; d_len = x.d_len;
        d_wdata = x.d_wdata; mem_ready = x.rdy; mem_rdata = x.rd_in;
        #1;
        chk($sformatf("vec%0d flags", idx), {26'd0, i_gnt, d_gnt, i_ack, d_ack, i_done, d_done},
            {26'd0, x.e_flags});
        chk($sformatf("vec%0d mem_req", idx), {31'd0, mem_req}, {31'd0, x.e_req});
        chk($sformatf("vec%0d mem_we", idx), {31'd0, mem_we}, {31'd0, x.e_we});
        chk($sformatf("vec%0d mem_addr", idx), mem_addr, x.e_addr);
        chk($sformatf("vec%0d mem_wdata", idx), mem_wdata, x.d_wdata);
        chk($sformatf("vec%0d rdata", idx), rdata, x.rd_in);
    endtask

    // Invariants checked every cycle while out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("one_gnt", {31'd0, i_gnt & d_gnt}, 32'd0);
            chk("ack_owner", {31'd0, (i_ack & ~i_gnt) | (d_ack & ~d_gnt)}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  gcount;
    bit  owners[5];
    logic pi, pd;
    bit  ok;

    initial begin
        reset_n = 1'b0;
        i_req = 0; i_addr = 0; i_len = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_len = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        #12;
        chk("rst i_gnt", {31'd0, i_gnt}, 32'd0);
        chk("rst d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single I burst, 4 beats; mem_ready high while IDLE must not ack.
        v(1, 32'h100, 3, 0, 0, 0, 0, 0, 1, 32'hD0, 6'b000000, 0, 0, 32'h0);
        v(1, 32'h100, 3, 0, 0, 0, 0, 0, 1, 32'hD1, 6'b101000, 1, 0, 32'h100);
        v(1, 32'h100, 3, 0, 0, 0, 0, 0, 1, 32'hD2, 6'b101000, 1, 0, 32'h104);
        v(1, 32'h100, 3, 0, 0, 0, 0, 0, 1, 32'hD3, 6'b101000, 1, 0, 32'h108);
        v(1, 32'h100, 3, 0, 0, 0, 0, 0, 1, 32'hD4, 6'b101010, 1, 0, 32'h10C);
        v(0, 32'h100, 3, 0, 0, 0, 0, 0, 1, 32'hD5, 6'b000000, 0, 0, 32'h110);
        // Tie: D first, then I in the following IDLE.
        v(1, 32'h300, 0, 1, 0, 32'h400, 0, 0, 1, 32'hE0, 6'b000000, 0, 0, 32'h110);
        v(1, 32'h300, 0, 1, 0, 32'h400, 0, 0, 1, 32'hE1, 6'b010101, 1, 0, 32'h400);
        v(1, 32'h300, 0, 0, 0, 32'h400, 0, 0, 1, 32'hE2, 6'b000000, 0, 0, 32'h404);
        v(1, 32'h300, 0, 0, 0, 32'h400, 0, 0, 1, 32'hE3, 6'b101010, 1, 0, 32'h300);
        v(0, 32'h300, 0, 0, 0, 32'h400, 0, 0, 1, 32'hE4, 6'b000000, 0, 0, 32'h304);
        // D write burst with wait states: ready 0,0,1,0,1.
        v(0, 0, 0, 1, 1, 32'h2000, 1, 32'hA0, 0, 32'hF0, 6'b000000, 0, 0, 32'h304);
        v(0, 0, 0, 1, 1, 32'h2000, 1, 32'hA1, 0, 32'hF1, 6'b010000, 1, 1, 32'h2000);
        v(0, 0, 0, 1, 1, 32'h2000, 1, 32'hA1, 0, 32'hF2, 6'b010000, 1, 1, 32'h2000);
        v(0, 0, 0, 1, 1, 32'h2000, 1, 32'hA1, 1, 32'hF3, 6'b010100, 1, 1, 32'h2000);
        v(0, 0, 0, 1, 1, 32'h2000, 1, 32'hA2, 0, 32'hF4, 6'b010000, 1, 1, 32'h2004);
        v(0, 0, 0, 1, 1, 32'h2000, 1, 32'hA2, 1, 32'hF5, 6'b010101, 1, 1, 32'h2004);
        v(0, 0, 0, 0, 1, 32'h2000, 1, 32'hA2, 0, 32'hF6, 6'b000000, 0, 0, 32'h2008);

        for (int k = 0; k < vq.size(); k++) apply(vq[k], k);

        // Starvation: both held high, expect D,D,D,D then I.
        @(negedge clk);
        i_req = 1; i_addr = 32'h700; i_len = 0;
        d_req = 1; d_we = 0; d_addr = 32'h800; d_len = 0; mem_ready = 1;
        gcount = 0; pi = 0; pd = 0;
        for (int k = 0; k < 60 && gcount < 5; k++) begin
            @(negedge clk); #1;
            if (i_gnt && !pi) begin
                owners[gcount] = 1'b1;
                gcount++;
                chk("starve cleared on I grant", {29'd0, dut.starve_cnt}, 32'd0);
            end
            if (d_gnt && !pd) begin
                owners[gcount] = 1'b0;
                gcount++;
                if (gcount == 4) chk("starve at limit", {29'd0, dut.starve_cnt}, 32'd4);
            end
            pi = i_gnt; pd = d_gnt;
        end
        i_req = 0; d_req = 0;
        chk("starve grants seen", gcount, 32'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("starve owner%0d", k), {31'd0, owners[k]}, (k == 4) ? 32'd1 : 32'd0);
        @(negedge clk); @(negedge clk);

        // Reset during beat 2 of an 8-beat I burst.
        i_req = 1; i_addr = 32'h500; i_len = 7; mem_ready = 1;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk); #1;
            if (i_gnt) ok = 1;
        end
        chk("rst burst gnt seen", {31'd0, ok}, 32'd1);
        @(negedge clk); #1;
        chk("rst burst beat2 addr", mem_addr, 32'h504);
        reset_n = 0; i_req = 0;
        #1;
        chk("async mem_req", {31'd0, mem_req}, 32'd0);
        chk("async i_gnt", {31'd0, i_gnt}, 32'd0);
        chk("async i_done", {31'd0, i_done}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        d_req = 1; d_we = 1; d_addr = 32'h600; d_len = 0; d_wdata = 32'h55;
        #1;
        chk("post rst idle", {31'd0, mem_req}, 32'd0);
        @(negedge clk); #1;
        chk("post rst d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("post rst mem_addr", mem_addr, 32'h600);
        chk("post rst mem_we", {31'd0, mem_we}, 32'd1);
        chk("post rst d_done", {31'd0, d_done}, 32'd1);
        chk("post rst no i_done", {31'd0, i_done}, 32'd0);
        d_req = 0;
        @(negedge clk);

        // Address wrap with i_req dropped after the first ack.
        @(negedge clk);
        i_req = 1; i_addr = 32'hFFFF_FFFC; i_len = 1; mem_ready = 1;
        #1;
        chk("wrap idle gnt", {31'd0, i_gnt}, 32'd0);
        @(negedge clk); #1;
        chk("wrap beat1 gnt", {31'd0, i_gnt}, 32'd1);
        chk("wrap beat1 addr", mem_addr, 32'hFFFF_FFFC);
        chk("wrap beat1 ack", {31'd0, i_ack}, 32'd1);
        chk("wrap beat1 done", {31'd0, i_done}, 32'd0);
        i_req = 0;
        @(negedge clk); #1;
        chk("wrap beat2 addr", mem_addr, 32'h0);
        chk("wrap beat2 ack", {31'd0, i_ack}, 32'd1);
        chk("wrap beat2 done", {31'd0, i_done}, 32'd1);
        @(negedge clk); #1;
        chk("wrap end gnt", {31'd0, i_gnt}, 32'd0);
        chk("wrap end mem_req", {31'd0, mem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
